register_scoreboard: RTL and testbench

- Producer-side companion to the operand forwarding path.
- Tracks which architectural registers have in-flight writes whose results are not yet forwardable. Sources: load data still in memory, and multi-cycle mul/div results awaiting completion.
- Raises a decode-stage stall whenever a consumer reads such a register, or issues a write over a register still awaiting multi-cycle completion (WAW).
- Sits beside decode; the forwarding unit handles every case this block does not stall.

---
 rtl/register_scoreboard.sv | 138 +++++++++++++
 tb/tb_register_scoreboard.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - decode-side scoreboard for non-forwardable in-flight register writes
//
// Ports:
//   clk                 rising-edge clock
//   reset               asynchronous active-low reset
//   issue_valid         decode instruction advances this cycle (ignored while stall=1)
//   issue_write_enable  issuing instruction writes rd
//   issue_rd[4:0]       destination of the issuing instruction
//   issue_delay[2:0]    0 = forwardable next cycle, 1..MAX_DELAY = countdown, MULTI_CODE = wait for complete
//   rs1_index/rs2_index source indices of the instruction in decode
//   rs1_read/rs2_read   instruction in decode uses that source
//   complete_valid      multi-cycle result becomes forwardable this cycle
//   complete_rd[4:0]    destination of the completing multi-cycle result
//   flush               drop all pending entries at the next edge
//   stall               hold decode (combinational)
//   busy_vector[31:0]   registered per-register pending flags, bit 0 always 0
//   pending_count[5:0]  registered popcount of busy_vector
//   protocol_error      sticky, complete seen for a register not awaiting completion

module register_scoreboard #(
   parameter int MAX_DELAY  = 6,
   parameter int MULTI_CODE = 7
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid,
   input  logic        issue_write_enable,
   input  logic [4:0]  issue_rd,
   input  logic [2:0]  issue_delay,
   input  logic [4:0]  rs1_index,
   input  logic [4:0]  rs2_index,
   input  logic        rs1_read,
   input  logic        rs2_read,
   input  logic        complete_valid,
   input  logic [4:0]  complete_rd,
   input  logic        flush,
   output logic        stall,
   output logic [31:0] busy_vector,
   output logic [5:0]  pending_count,
   output logic        protocol_error
);

   logic [31:0]       busy_q, busy_d;
   logic [31:0]       wc_q, wc_d;
   logic [31:0][2:0]  cnt_q, cnt_d;
   logic [5:0]        count_q, count_d;
   logic              err_q, err_d;
   logic              raw_hazard;
   logic              waw_hazard;
   logic              accept;

   // Bit 0 of busy_q/wc_q is held at zero, so x0 never matches here.
   always_comb begin
      raw_hazard = (rs1_read && (rs1_index != 5'd0) && busy_q[rs1_index]) ||
                   (rs2_read && (rs2_index != 5'd0) && busy_q[rs2_index]);
      waw_hazard = issue_valid && issue_write_enable && (issue_rd != 5'd0) && wc_q[issue_rd];
      stall      = raw_hazard || waw_hazard;
      accept     = issue_valid && !stall && !flush && issue_write_enable && (issue_rd != 5'd0);
   end

   always_comb begin
      busy_d  = busy_q;
      wc_d    = wc_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      count_d = 6'd0;

      // Fixed-latency entries tick down; busy drops on the edge where the count hits zero.
      for (int i = 1; i < 32; i++) begin
         if (busy_q[i] && !wc_q[i]) begin
            cnt_d[i] = cnt_q[i] - 3'd1;
            if (cnt_q[i] <= 3'd1) begin
               busy_d[i] = 1'b0;
               cnt_d[i]  = 3'd0;
            end
         end
      end

      if (complete_valid && (complete_rd != 5'd0)) begin
         if (wc_q[complete_rd]) begin
            busy_d[complete_rd] = 1'b0;
            wc_d[complete_rd]   = 1'b0;
            cnt_d[complete_rd]  = 3'd0;
         end else begin
            err_d = 1'b1;
         end
      end

      // Issue is applied last so a reload beats a same-cycle countdown expiry.
      if (accept) begin
         if (issue_delay == 3'(MULTI_CODE)) begin
            busy_d[issue_rd] = 1'b1;
            wc_d[issue_rd]   = 1'b1;
            cnt_d[issue_rd]  = 3'd0;
         end else if (issue_delay != 3'd0) begin
            busy_d[issue_rd] = 1'b1;
            wc_d[issue_rd]   = 1'b0;
            cnt_d[issue_rd]  = (issue_delay > 3'(MAX_DELAY)) ? 3'(MAX_DELAY) : issue_delay;
         end
      end

      // Flush discards everything this cycle except the sticky error flag.
      if (flush) begin
         busy_d = '0;
         wc_d   = '0;
         cnt_d  = '0;
         err_d  = err_q;
      end

      busy_d[0] = 1'b0;
      wc_d[0]   = 1'b0;

      for (int i = 1; i < 32; i++) begin
         count_d = count_d + 6'(busy_d[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_q  <= '0;
         wc_q    <= '0;
         cnt_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         busy_q  <= busy_d;
         wc_q    <= wc_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign busy_vector    = busy_q;
   assign pending_count  = count_q;
   assign protocol_error = err_q;

endmodule

// File: tb/tb_register_scoreboard.sv
// tb/tb_register_scoreboard.sv - self-checking bench for register_scoreboard

module tb_register_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic        issue_valid, issue_write_enable;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_delay;
   logic [4:0]  rs1_index, rs2_index;
   logic        rs1_read, rs2_read;
   logic        complete_valid;
   logic [4:0]  complete_rd;
   logic        flush;
   logic        stall;
   logic [31:0] busy_vector;
   logic [5:0]  pending_count;
   logic        protocol_error;

   int checks = 0;
   int errors = 0;

   register_scoreboard dut (
      .clk(clk), .reset(reset),
      .issue_valid(issue_valid), .issue_write_enable(issue_write_enable),
      .issue_rd(issue_rd), .issue_delay(issue_delay),
      .rs1_index(rs1_index), .rs2_index(rs2_index),
      .rs1_read(rs1_read), .rs2_read(rs2_read),
      .complete_valid(complete_valid), .complete_rd(complete_rd),
      .flush(flush), .stall(stall), .busy_vector(busy_vector),
      .pending_count(pending_count), .protocol_error(protocol_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv, we;
      logic [4:0]  rd;
      logic [2:0]  dl;
      logic [4:0]  s1;
      logic        r1;
      logic [4:0]  s2;
      logic        r2;
      logic        cv;
      logic [4:0]  crd;
      logic        fl;
      logic        st;
      logic [31:0] bv;
      logic [5:0]  pc;
      logic        er;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic iv, logic we, logic [4:0] rd, logic [2:0] dl,
                               logic [4:0] s1, logic r1, logic [4:0] s2, logic r2,
                               logic cv, logic [4:0] crd, logic fl,
                               logic st, logic [31:0] bv, logic [5:0] pc, logic er);
      vec_t v;
      v.iv = iv; v.we = we; v.rd = rd; v.dl = dl;
      v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2;
      v.cv = cv; v.crd = crd; v.fl = fl;
      v.st = st; v.bv = bv; v.pc = pc; v.er = er;
      return v;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(logic iv, logic we, logic [4:0] rd, logic [2:0] dl,
                        logic [4:0] s1, logic r1, logic [4:0] s2, logic r2,
                        logic cv, logic [4:0] crd, logic fl);
      issue_valid = iv; issue_write_enable = we; issue_rd = rd; issue_delay = dl;
      rs1_index = s1; rs1_read = r1; rs2_index = s2; rs2_read = r2;
      complete_valid = cv; complete_rd = crd; flush = fl;
   endtask

   // Reference model: remaining busy cycles per register, or waiting on a completion.
   int rem[32];
   bit waitc[32];
   bit perr;

   function automatic bit m_busy(int r);
      return (r != 0) && (waitc[r] || rem[r] > 0);
   endfunction

   function automatic bit m_stall();
      return (rs1_read && m_busy(int'(rs1_index))) ||
             (rs2_read && m_busy(int'(rs2_index))) ||
             (issue_valid && issue_write_enable && issue_rd != 0 && waitc[issue_rd]);
   endfunction

   function automatic logic [31:0] m_vec();
      logic [31:0] v = '0;
      for (int i = 1; i < 32; i++) v[i] = m_busy(i);
      return v;
   endfunction

   task automatic m_edge();
      bit acc;
      acc = issue_valid && !m_stall() && !flush && issue_write_enable && issue_rd != 0;
      if (flush) begin
         for (int i = 0; i < 32; i++) begin rem[i] = 0; waitc[i] = 0; end
      end else begin
         for (int i = 1; i < 32; i++) if (!waitc[i] && rem[i] > 0) rem[i]--;
         if (complete_valid && complete_rd != 0) begin
            if (waitc[complete_rd]) begin waitc[complete_rd] = 0; rem[complete_rd] = 0; end
            else perr = 1;
         end
         if (acc) begin
            if (issue_delay == 3'd7) begin waitc[issue_rd] = 1; rem[issue_rd] = 0; end
            else if (issue_delay != 3'd0) begin waitc[issue_rd] = 0; rem[issue_rd] = int'(issue_delay); end
         end
      end
   endtask

   initial begin
      drive(0,0,0,0, 0,0,0,0, 0,0,0);
      reset = 1'b0;
      #12;
      check("reset_busy", busy_vector, 32'h0);
      check("reset_count", 32'(pending_count), 32'h0);
      check("reset_err", 32'(protocol_error), 32'h0);
      rs1_index = 5'd5; rs1_read = 1'b1; #1;
      check("reset_stall", 32'(stall), 32'h0);
      rs1_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;

      //       iv we rd dl   s1 r1 s2 r2  cv crd fl   st  bv             pc er
      vecs.push_back(mk(1,1, 5,1,  5,1, 0,0,  0, 0,0,  0, 32'h00000020, 1,0));
      vecs.push_back(mk(0,0, 0,0,  5,1, 0,0,  0, 0,0,  1, 32'h00000000, 0,0));
      vecs.push_back(mk(0,0, 0,0,  5,1, 0,0,  0, 0,0,  0, 32'h00000000, 0,0));
      vecs.push_back(mk(1,1,10,7,  0,0,10,1,  0, 0,0,  0, 32'h00000400, 1,0));
      vecs.push_back(mk(0,0, 0,0,  0,0,10,1,  0, 0,0,  1, 32'h00000400, 1,0));
      vecs.push_back(mk(0,0, 0,0,  0,0,10,1,  0, 0,0,  1, 32'h00000400, 1,0));
      vecs.push_back(mk(0,0, 0,0,  0,0,10,1,  1,10,0,  1, 32'h00000000, 0,0));
      vecs.push_back(mk(0,0, 0,0,  0,0,10,1,  0, 0,0,  0, 32'h00000000, 0,0));
      vecs.push_back(mk(1,1,10,7,  0,0, 0,0,  0, 0,0,  0, 32'h00000400, 1,0));
      vecs.push_back(mk(1,1,10,1,  0,0, 0,0,  0, 0,0,  1, 32'h00000400, 1,0));
      vecs.push_back(mk(1,1,10,1,  0,0, 0,0,  1,10,0,  1, 32'h00000000, 0,0));
      vecs.push_back(mk(1,1,10,1,  0,0, 0,0,  0, 0,0,  0, 32'h00000400, 1,0));
      vecs.push_back(mk(0,0, 0,0,  0,0, 0,0,  0, 0,0,  0, 32'h00000000, 0,0));
      vecs.push_back(mk(1,1, 3,3,  0,0, 0,0,  0, 0,0,  0, 32'h00000008, 1,0));
      vecs.push_back(mk(1,1, 4,7,  0,0, 0,0,  0, 0,0,  0, 32'h00000018, 2,0));
      vecs.push_back(mk(1,1, 7,2,  0,0, 0,0,  0, 0,0,  0, 32'h00000098, 3,0));
      vecs.push_back(mk(1,1, 9,2,  0,0, 0,0,  0, 0,1,  0, 32'h00000000, 0,0));
      vecs.push_back(mk(0,0, 0,0,  0,0, 0,0,  0, 0,0,  0, 32'h00000000, 0,0));
      vecs.push_back(mk(0,0, 0,0,  0,0, 0,0,  1, 9,0,  0, 32'h00000000, 0,1));
      vecs.push_back(mk(1,1, 0,7,  0,0, 0,0,  0, 0,0,  0, 32'h00000000, 0,1));
      vecs.push_back(mk(0,0, 0,0,  0,0, 0,0,  1, 0,0,  0, 32'h00000000, 0,1));
      vecs.push_back(mk(1,0, 6,3,  6,1, 0,0,  0, 0,0,  0, 32'h00000000, 0,1));

      foreach (vecs[k]) begin
         vec_t v = vecs[k];
         drive(v.iv, v.we, v.rd, v.dl, v.s1, v.r1, v.s2, v.r2, v.cv, v.crd, v.fl);
         #1;
         check($sformatf("vec%0d_stall", k), 32'(stall), 32'(v.st));
         @(posedge clk); #1;
         check($sformatf("vec%0d_busy", k), busy_vector, v.bv);
         check($sformatf("vec%0d_count", k), 32'(pending_count), 32'(v.pc));
         check($sformatf("vec%0d_err", k), 32'(protocol_error), 32'(v.er));
      end

      // Asynchronous reset in the middle of a countdown (x12 delay 5, count now 3).
      drive(1,1,12,5, 0,0,0,0, 0,0,0);
      @(posedge clk); #1;
      drive(0,0,0,0, 12,1,0,0, 0,0,0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_busy", busy_vector, 32'h00001000);
      check("mid_stall", 32'(stall), 32'h1);
      reset = 1'b0;
      #1;
      check("async_busy", busy_vector, 32'h0);
      check("async_count", 32'(pending_count), 32'h0);
      check("async_err", 32'(protocol_error), 32'h0);
      check("async_stall", 32'(stall), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      drive(0,0,0,0, 0,0,0,0, 0,0,0);

      for (int i = 0; i < 32; i++) begin rem[i] = 0; waitc[i] = 0; end
      perr = 0;

      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0,1)), 1'($urandom_range(0,3) != 0),
               5'($urandom_range(0,7)), 3'($urandom_range(0,7)),
               5'($urandom_range(0,7)), 1'($urandom_range(0,1)),
               5'($urandom_range(0,7)), 1'($urandom_range(0,1)),
               1'($urandom_range(0,3) == 0), 5'($urandom_range(0,7)),
               1'($urandom_range(0,31) == 0));
         #1;
         check("rand_stall", 32'(stall), 32'(m_stall()));
         m_edge();
         @(posedge clk); #1;
         check("rand_busy", busy_vector, m_vec());
         check("rand_count", 32'(pending_count), 32'($countones(m_vec())));
         check("rand_err", 32'(protocol_error), 32'(perr));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
